sw_word_loader: RTL and testbench

- Operator-input path into the CPU data memory, the reverse direction of the LED readout path.
- Assembles a 32-bit word and a word address from 4-bit SW entries, one debounced button press per nibble.
- Issues a single write request to the memory write port and holds it until acknowledged.
- Drives an 8-bit LED progress display.

---
 rtl/sw_word_loader.sv | 153 +++++++++++++++
 tb/tb_sw_word_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_word_loader.sv
// sw_word_loader: builds a 32-bit word and a word address from 4-bit switch
// entries. Each entry is committed by one debounced press of Enter_BTN. The
// loader then raises a single write request and holds it until the memory side
// acknowledges it.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_DATA  | collecting data nibbles, most significant first (8 presses)
// S_ADDR  | collecting address nibbles, high nibble first (2 presses)
// S_WRITE | Wr_Req held with stable data/address until Wr_Ack
module sw_word_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ADDR_W          = 6
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [3:0]        SW,
  input  logic              Enter_BTN,
  output logic [31:0]       W_Data,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              Wr_Req,
  input  logic              Wr_Ack,
  output logic              Busy,
  output logic [7:0]        LED
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_ADDR  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  logic [1:0]       sync_q;
  logic             deb_level;
  logic             deb_prev;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;

  state_t           state, state_nxt;
  logic [3:0]       nib_cnt, nib_cnt_nxt;
  logic [3:0]       addr_hi, addr_hi_nxt;
  logic [2:0]       led_sw, led_sw_nxt;
  logic [31:0]      data_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // Synchronise the raw button and accept a level only after it has been
  // stable for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_q   <= {sync_q[0], Enter_BTN};
      deb_prev <= deb_level;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_level <= sync_q[1];
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // Single-cycle press on the debounced rising edge.
  assign press = deb_level & ~deb_prev;

  // State and entry registers; a reset abandons any pending write at once.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state   <= S_DATA;
      nib_cnt <= '0;
      addr_hi <= '0;
      led_sw  <= '0;
      W_Data  <= '0;
      W_Addr  <= '0;
    end else begin
      state   <= state_nxt;
      nib_cnt <= nib_cnt_nxt;
      addr_hi <= addr_hi_nxt;
      led_sw  <= led_sw_nxt;
      W_Data  <= data_nxt;
      W_Addr  <= addr_nxt;
    end
  end

  // Next-state logic: presses shift nibbles in; ack closes the write and wins
  // over a coincident press, which is simply dropped.
  always_comb begin
    state_nxt   = state;
    nib_cnt_nxt = nib_cnt;
    addr_hi_nxt = addr_hi;
    led_sw_nxt  = led_sw;
    data_nxt    = W_Data;
    addr_nxt    = W_Addr;
    case (state)
      S_DATA: begin
        if (press) begin
          data_nxt   = {W_Data[27:0], SW};
          led_sw_nxt = SW[2:0];
          if (nib_cnt == 4'd7) begin
            nib_cnt_nxt = '0;
            state_nxt   = S_ADDR;
          end else begin
            nib_cnt_nxt = nib_cnt + 4'd1;
          end
        end
      end
      S_ADDR: begin
        if (press) begin
          led_sw_nxt = SW[2:0];
          if (nib_cnt == 4'd1) begin
            addr_nxt    = ADDR_W'({addr_hi, SW});
            nib_cnt_nxt = '0;
            state_nxt   = S_WRITE;
          end else begin
            addr_hi_nxt = SW;
            nib_cnt_nxt = nib_cnt + 4'd1;
          end
        end
      end
      S_WRITE: begin
        if (Wr_Ack) begin
          data_nxt    = '0;
          nib_cnt_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      default: begin
        state_nxt   = S_DATA;
        nib_cnt_nxt = '0;
      end
    endcase
  end

  // Request and busy are exactly "in WRITE"; LED shows progress or all-on.
  always_comb begin
    Wr_Req = (state == S_WRITE);
    Busy   = (state == S_WRITE);
    if (state == S_WRITE) begin
      LED = 8'hFF;
    end else begin
      LED = {nib_cnt, (state == S_ADDR), led_sw};
    end
  end

endmodule

// File: tb/tb_sw_word_loader.sv
// Bench for sw_word_loader with a short debounce window.
module tb_sw_word_loader;

  localparam int D  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    SW = '0;
  logic          Enter_BTN = 1'b0;
  logic          Wr_Ack = 1'b0;
  logic [31:0]   W_Data;
  logic [AW-1:0] W_Addr;
  logic          Wr_Req;
  logic          Busy;
  logic [7:0]    LED;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  sw_word_loader #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
    .clk_100MHz(clk),
    .rst(rst),
    .SW(SW),
    .Enter_BTN(Enter_BTN),
    .W_Data(W_Data),
    .W_Addr(W_Addr),
    .Wr_Req(Wr_Req),
    .Wr_Ack(Wr_Ack),
    .Busy(Busy),
    .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=data entry, 1=address entry, 2=write pending.
  // A press is declared when the last D synchronised samples all disagree
  // with the accepted level and the new level is 1.
  int            m_phase;
  int            m_cnt;
  logic [31:0]   m_data;
  logic [7:0]    m_addr_sr;
  logic [AW-1:0] m_waddr;
  logic [2:0]    m_led_sw;
  logic          m_deb;
  logic          m_press;
  logic [D+1:0]  m_hist;
  logic          m_stable;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_data = '0; m_addr_sr = '0; m_waddr = '0;
      m_led_sw = '0; m_deb = 1'b0; m_press = 1'b0; m_hist = '0;
    end else begin
      if (m_phase == 2) begin
        if (Wr_Ack) begin
          m_phase = 0; m_data = '0; m_cnt = 0;
        end
      end else if (m_press) begin
        m_led_sw = SW[2:0];
        m_cnt++;
        if (m_phase == 0) begin
          m_data = {m_data[27:0], SW};
          if (m_cnt == 8) begin m_cnt = 0; m_phase = 1; end
        end else begin
          m_addr_sr = {m_addr_sr[3:0], SW};
          if (m_cnt == 2) begin
            m_cnt = 0; m_phase = 2; m_waddr = m_addr_sr[AW-1:0];
          end
        end
      end
      m_hist = {m_hist[D:0], Enter_BTN};
      m_stable = 1'b1;
      for (int i = 2; i <= D + 1; i++) if (m_hist[i] == m_deb) m_stable = 1'b0;
      m_press = 1'b0;
      if (m_stable) begin
        m_deb = ~m_deb;
        m_press = m_deb;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cyc_wdata", W_Data, m_data);
      check("cyc_waddr", 32'(W_Addr), 32'(m_waddr));
      check("cyc_wreq", 32'(Wr_Req), 32'(m_phase == 2));
      check("cyc_busy", 32'(Busy), 32'(m_phase == 2));
      check("cyc_led", 32'(LED),
            (m_phase == 2) ? 32'hFF : 32'({m_cnt[3:0], (m_phase == 1), m_led_sw}));
    end
  end

  task automatic press(input logic [3:0] v);
    SW = v;
    Enter_BTN = 1'b1;
    repeat (D + 4) @(negedge clk);
    Enter_BTN = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    Wr_Ack = 1'b1;
    @(negedge clk);
    Wr_Ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wdata", W_Data, 32'h0);
    check("rst_waddr", 32'(W_Addr), 32'h0);
    check("rst_wreq", 32'(Wr_Req), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_led", 32'(LED), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Bouncy button: 2-cycle toggles must be rejected, then a clean rise.
    SW = 4'h5;
    for (int i = 0; i < 20; i++) begin
      Enter_BTN = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    check("bounce_no_press", 32'(LED), 32'h0);
    Enter_BTN = 1'b1;
    repeat (6) @(negedge clk);
    check("deb_before_latency", 32'(LED[7:4]), 32'h0);
    @(negedge clk);
    check("deb_one_press_led", 32'(LED), 32'h15);
    check("deb_one_press_data", W_Data, 32'h5);
    repeat (D) @(negedge clk);
    Enter_BTN = 1'b0;
    repeat (D + 4) @(negedge clk);
    check("deb_single_pulse", 32'(LED[7:4]), 32'h1);
    do_reset();

    // Full entry and a held request.
    for (int i = 1; i <= 8; i++) press(4'(i));
    press(4'h3);
    press(4'hC);
    check("entry_wdata", W_Data, 32'h12345678);
    check("entry_waddr", 32'(W_Addr), 32'h3C);
    check("entry_wreq", 32'(Wr_Req), 32'h1);
    check("entry_busy", 32'(Busy), 32'h1);
    check("entry_led", 32'(LED), 32'hFF);
    repeat (50) @(negedge clk);
    check("hold_wreq", 32'(Wr_Req), 32'h1);

    // Handshake, then a stray ack outside WRITE.
    Wr_Ack = 1'b1;
    @(negedge clk);
    Wr_Ack = 1'b0;
    check("ack_wreq", 32'(Wr_Req), 32'h0);
    check("ack_busy", 32'(Busy), 32'h0);
    check("ack_wdata", W_Data, 32'h0);
    check("ack_led_cnt", 32'(LED[7:4]), 32'h0);
    ack_pulse();
    check("stray_ack_wreq", 32'(Wr_Req), 32'h0);
    check("stray_ack_led", 32'(LED), 32'h04);

    // Address truncation and presses ignored while writing.
    for (int i = 0; i < 8; i++) press(4'(4'h9 + i));
    press(4'hF);
    press(4'hF);
    check("trunc_waddr", 32'(W_Addr), 32'h3F);
    check("trunc_wdata", W_Data, 32'h9ABCDEF0);
    SW = 4'hF;
    for (int i = 0; i < 3; i++) press(4'hF);
    check("ign_wdata", W_Data, 32'h9ABCDEF0);
    check("ign_led", 32'(LED), 32'hFF);
    check("ign_waddr", 32'(W_Addr), 32'h3F);
    ack_pulse();
    check("ign_after_ack_led", 32'(LED), 32'h07);
    for (int i = 0; i < 8; i++) press(4'hA);
    check("ign_fresh_wdata", W_Data, 32'hAAAAAAAA);
    check("ign_fresh_led", 32'(LED), 32'h0A);

    // Asynchronous reset mid-entry.
    do_reset();
    for (int i = 1; i <= 5; i++) press(4'(i));
    check("mid_partial", W_Data, 32'h00012345);
    #1 rst = 1'b1;
    #1;
    check("async_wdata", W_Data, 32'h0);
    check("async_led", 32'(LED), 32'h0);
    check("async_wreq", 32'(Wr_Req), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) press(4'(8 - i));
    check("fresh_wdata", W_Data, 32'h87654321);
    check("fresh_led", 32'(LED), 32'h09);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
